// File: rtl/dlsc_mt9v032_pkg.sv
// Shared types and helpers for the MT9V032 multi-camera lock-stepper.
package dlsc_mt9v032_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dlsc_mt9v032_lockstep_fifo.sv
// Per-channel skew FIFO: synchronous, show-ahead (head valid right after the
// push edge), with a synchronous flush that empties it in one cycle.
module dlsc_mt9v032_lockstep_fifo #(
  parameter int WIDTH = 11,
  parameter int ADDR  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam logic [ADDR:0] DEPTH = (ADDR+1)'(2**ADDR);

  logic [WIDTH-1:0] r_mem [2**ADDR];
  logic [ADDR-1:0]  r_wr;
  logic [ADDR-1:0]  r_rd;
  logic [ADDR:0]    r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == DEPTH);
  assign w_wr    = i_push && !o_full && !i_flush;
  assign w_rd    = i_pop && !o_empty && !i_flush;
  assign o_data  = r_mem[r_rd];

  // Pointer and occupancy bookkeeping; flush discards everything stored.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + ADDR'(1);
      if (w_rd) r_rd <= r_rd + ADDR'(1);
      r_cnt <= r_cnt + (ADDR+1)'(w_wr) - (ADDR+1)'(w_rd);
    end
  end

  // Storage array; contents are don't-care while empty so it has no reset.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/dlsc_mt9v032_lockstep.sv
// Multi-camera pixel lock-stepper: buffers per-channel skew, aligns every
// channel on its first-pixel flag and emits one wide beat per pixel position.
// Optional first-flag sync checking is built when
// DLSC_MT9V032_LOCKSTEP_CHECK_EN is defined.
module dlsc_mt9v032_lockstep
  import dlsc_mt9v032_pkg::*;
#(
  parameter int CAMERAS   = 2,
  parameter int DATA      = 10,
  parameter int HDISP     = 752,
  parameter int VDISP     = 480,
  parameter int FIFO_ADDR = 4
) (
  input  logic                    px_clk,
  input  logic                    px_rst,
  input  logic                    enable,
  output logic [CAMERAS-1:0]      in_ready,
  input  logic [CAMERAS-1:0]      in_valid,
  input  logic [CAMERAS-1:0]      in_first,
  input  logic [CAMERAS*DATA-1:0] in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic [CAMERAS*DATA-1:0] out_data,
  output logic [15:0]             frame_count,
  output logic [7:0]              err_count,
  output logic                    sync_err
);

  localparam int XW = cnt_w(HDISP);
  localparam int YW = cnt_w(VDISP);
  localparam logic [XW-1:0] X_LAST = XW'(HDISP-1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP-1);

  state_t             r_state;
  logic [CAMERAS-1:0] r_aligned;
  logic [XW-1:0]      r_x;
  logic [YW-1:0]      r_y;
  logic [15:0]        r_frames;

  logic [CAMERAS-1:0] w_empty;
  logic [CAMERAS-1:0] w_full;
  logic [CAMERAS-1:0] w_head_first;
  logic [DATA-1:0]    w_head_data [CAMERAS];
  logic [CAMERAS-1:0] w_push;
  logic [CAMERAS-1:0] w_align_set;
  logic [CAMERAS-1:0] w_aligned_nxt;
  logic               w_flush;
  logic               w_xfer;
  logic               w_mism;
  logic               w_at_origin;
  logic               w_at_end;

  genvar g;
  for (g = 0; g < CAMERAS; g++) begin : g_ch
    dlsc_mt9v032_lockstep_fifo #(
      .WIDTH (DATA+1),
      .ADDR  (FIFO_ADDR)
    ) u_fifo (
      .i_clk   (px_clk),
      .i_rst   (px_rst),
      .i_flush (w_flush),
      .i_push  (w_push[g]),
      .i_data  ({in_first[g], in_data[g*DATA +: DATA]}),
      .i_pop   (w_xfer),
      .o_data  ({w_head_first[g], w_head_data[g]}),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g])
    );
    assign out_data[g*DATA +: DATA] = out_valid ? w_head_data[g] : '0;
  end

  assign w_at_origin   = (r_x == '0) && (r_y == '0);
  assign w_at_end      = (r_x == X_LAST) && (r_y == Y_LAST);
  assign out_valid     = (r_state == ST_RUN) && !(|w_empty);
  assign out_first     = out_valid && w_at_origin;
  assign out_last      = out_valid && w_at_end;
  assign w_xfer        = out_valid && out_ready;
  assign w_aligned_nxt = r_aligned | w_align_set;
  assign w_flush       = (r_state == ST_IDLE) || !enable || w_mism;
  assign frame_count   = r_frames;
  assign sync_err      = w_mism && enable;

`ifdef DLSC_MT9V032_LOCKSTEP_CHECK_EN
  logic [7:0] r_errs;

  // Every head must carry a first flag exactly when the beat is pixel (0,0).
  assign w_mism    = w_xfer && (w_head_first != {CAMERAS{w_at_origin}});
  assign err_count = r_errs;

  // Saturating sync-error counter; a disable takes priority over an error.
  always_ff @(posedge px_clk) begin
    if (px_rst) r_errs <= '0;
    else if (sync_err && (r_errs != 8'hFF)) r_errs <= r_errs + 8'd1;
  end
`else
  logic w_unused_first;

  assign w_mism         = 1'b0;
  assign err_count      = '0;
  assign w_unused_first = ^w_head_first;
`endif

  // Per-channel accept and push: unaligned channels drop beats until in_first.
  always_comb begin
    in_ready    = '0;
    w_push      = '0;
    w_align_set = '0;
    for (int c = 0; c < CAMERAS; c++) begin
      if (r_state == ST_IDLE) begin
        in_ready[c] = 1'b1;
      end else if ((r_state == ST_ALIGN) && !r_aligned[c]) begin
        in_ready[c]    = 1'b1;
        w_align_set[c] = in_valid[c] && in_first[c];
        w_push[c]      = in_valid[c] && in_first[c];
      end else begin
        in_ready[c] = !w_full[c];
        w_push[c]   = in_valid[c] && !w_full[c];
      end
      if (px_rst) in_ready[c] = 1'b0;
    end
  end

  // Control state, alignment flags and pixel position / frame counters.
  always_ff @(posedge px_clk) begin
    if (px_rst) begin
      r_state   <= ST_IDLE;
      r_aligned <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_frames  <= '0;
    end else begin
      if (w_xfer) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          if (r_y == Y_LAST) begin
            r_y      <= '0;
            r_frames <= r_frames + 16'd1;
          end else begin
            r_y <= r_y + YW'(1);
          end
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
      if (!enable) begin
        r_state   <= ST_IDLE;
        r_aligned <= '0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            r_state   <= ST_ALIGN;
            r_aligned <= '0;
          end
          ST_ALIGN: begin
            r_aligned <= w_aligned_nxt;
            if (&w_aligned_nxt) begin
              r_state <= ST_RUN;
              r_x     <= '0;
              r_y     <= '0;
            end
          end
          default: begin
            if (w_mism) begin
              r_state   <= ST_ALIGN;
              r_aligned <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dlsc_mt9v032_lockstep.sv
// Randomized bench for dlsc_mt9v032_lockstep with a queue-based reference
// model of the lock-step behaviour (small 4x2 frames, 2 cameras).
module tb_dlsc_mt9v032_lockstep;

  localparam int CAM   = 2;
  localparam int DW    = 10;
  localparam int HD    = 4;
  localparam int VD    = 2;
  localparam int FA    = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = HD*VD;
  localparam int NCYC  = 3000;
`ifdef DLSC_MT9V032_LOCKSTEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic [CAM-1:0]    in_ready;
  logic [CAM-1:0]    in_valid = '0;
  logic [CAM-1:0]    in_first = '0;
  logic [CAM*DW-1:0] in_data = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic              out_first;
  logic              out_last;
  logic [CAM*DW-1:0] out_data;
  logic [15:0]       frame_count;
  logic [7:0]        err_count;
  logic              sync_err;

  dlsc_mt9v032_lockstep #(
    .CAMERAS   (CAM),
    .DATA      (DW),
    .HDISP     (HD),
    .VDISP     (VD),
    .FIFO_ADDR (FA)
  ) dut (
    .px_clk      (clk),
    .px_rst      (rst),
    .enable      (enable),
    .in_ready    (in_ready),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .in_data     (in_data),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_first   (out_first),
    .out_last    (out_last),
    .out_data    (out_data),
    .frame_count (frame_count),
    .err_count   (err_count),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 aligning, 2 running.
  int          m_mode = 0;
  logic [DW:0] mq [CAM][$];
  bit          mal [CAM];
  int          mx = 0, my = 0, mfc = 0, mec = 0;
  bit          acc [CAM];
  bit          run_chk = 1'b0;

  logic [CAM-1:0]    e_rdy;
  logic              e_ovld, e_first, e_last, e_serr, xfer, mism, all_al;
  logic [CAM*DW-1:0] e_data;
  bit                pushv [CAM];

  always @(negedge clk) begin
    if (run_chk) begin
      for (int c = 0; c < CAM; c++) begin
        if (rst) e_rdy[c] = 1'b0;
        else if (m_mode == 0) e_rdy[c] = 1'b1;
        else if (m_mode == 1 && !mal[c]) e_rdy[c] = 1'b1;
        else e_rdy[c] = (mq[c].size() < DEPTH);
      end
      e_ovld = (m_mode == 2);
      for (int c = 0; c < CAM; c++) if (mq[c].size() == 0) e_ovld = 1'b0;
      e_first = e_ovld && (mx == 0) && (my == 0);
      e_last  = e_ovld && (mx == HD-1) && (my == VD-1);
      e_data  = '0;
      if (e_ovld) for (int c = 0; c < CAM; c++) e_data[c*DW +: DW] = mq[c][0][DW-1:0];
      xfer = e_ovld && out_ready;
      mism = 1'b0;
      if (CHK && xfer) for (int c = 0; c < CAM; c++) if (mq[c][0][DW] != e_first) mism = 1'b1;
      e_serr = mism && enable;

      check_eq("in_ready",    in_ready,    e_rdy);
      check_eq("out_valid",   out_valid,   e_ovld);
      check_eq("out_data",    out_data,    e_data);
      check_eq("out_first",   out_first,   e_first);
      check_eq("out_last",    out_last,    e_last);
      check_eq("frame_count", frame_count, 64'(mfc & 16'hFFFF));
      check_eq("err_count",   err_count,   64'(mec));
      check_eq("sync_err",    sync_err,    e_serr);

      for (int c = 0; c < CAM; c++) acc[c] = in_valid[c] && e_rdy[c];

      // Advance the model across the coming clock edge.
      if (rst) begin
        m_mode = 0; mx = 0; my = 0; mfc = 0; mec = 0;
        for (int c = 0; c < CAM; c++) begin mq[c].delete(); mal[c] = 1'b0; end
      end else begin
        for (int c = 0; c < CAM; c++) begin
          if (m_mode == 1 && !mal[c]) pushv[c] = in_valid[c] && in_first[c];
          else pushv[c] = (m_mode != 0) && in_valid[c] && (mq[c].size() < DEPTH);
        end
        if (xfer) begin
          for (int c = 0; c < CAM; c++) void'(mq[c].pop_front());
          mx++;
          if (mx == HD) begin
            mx = 0; my++;
            if (my == VD) begin my = 0; mfc++; end
          end
        end
        if (!enable || mism) begin
          if (enable) begin
            m_mode = 1;
            if (mec < 255) mec++;
          end else begin
            m_mode = 0;
          end
          for (int c = 0; c < CAM; c++) begin mq[c].delete(); mal[c] = 1'b0; end
        end else if (m_mode == 0) begin
          m_mode = 1;
        end else begin
          for (int c = 0; c < CAM; c++) begin
            if (pushv[c]) begin
              mq[c].push_back({in_first[c], in_data[c*DW +: DW]});
              mal[c] = 1'b1;
            end
          end
          if (m_mode == 1) begin
            all_al = 1'b1;
            for (int c = 0; c < CAM; c++) if (!mal[c]) all_al = 1'b0;
            if (all_al) begin m_mode = 2; mx = 0; my = 0; end
          end
        end
      end
    end
  end

  // Stimulus: each camera walks its own frame position; channel 1 starts
  // mid-frame, spurious first flags are injected on channel 0 at pixel 5.
  int pos [CAM];
  bit glitch_arm = 1'b0;
  bit force_in;

  initial begin
    pos[0] = 0;
    pos[1] = 5;
    for (int c = 0; c < CAM; c++) begin
      acc[c] = 1'b0;
      mal[c] = 1'b0;
      in_data[c*DW +: DW] = DW'($urandom);
    end
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) run_chk = 1'b1;
      for (int c = 0; c < CAM; c++) begin
        if (acc[c]) begin
          if (c == 0 && glitch_arm && pos[0] == 5) glitch_arm = 1'b0;
          pos[c] = (pos[c] + 1) % FRAME;
          in_data[c*DW +: DW] = DW'($urandom);
        end
      end
      rst    = (i < 3) || (i >= 2000 && i < 2002);
      enable = !((i < 6) || (i >= 1200 && i < 1230));
      if (i == 400 || i == 1500 || i == 2500) glitch_arm = 1'b1;
      force_in  = (i >= 700 && i < 740);
      out_ready = force_in ? 1'b0 : ($urandom_range(0, 3) != 0);
      for (int c = 0; c < CAM; c++) begin
        if (force_in) in_valid[c] = 1'b1;
        else if (!(in_valid[c] && !acc[c])) in_valid[c] = ($urandom_range(0, 9) < 8);
        in_first[c] = (pos[c] == 0) || (c == 0 && glitch_arm && pos[0] == 5);
      end
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
